// File: rtl/sound_fifo.sv
// Sample FIFO with rate timer replaying bytes onto the four Soundrive DAC channel registers.
// Define SOUND_FIFO_IRQ_EN to add the half-empty irq output.
module sound_fifo #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned DIV_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            data_in,
    input  logic                  fifo_wr,
    input  logic                  fifo_clr,
    input  logic                  enable,
    input  logic                  stereo,
    input  logic [DIV_W-1:0]      rate_div,
    output logic [7:0]            sd_data,
    output logic [1:0]            sd_sel,
    output logic                  sd_wr,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf,
    output logic                  unf
`ifdef SOUND_FIFO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {StIdle, StW0, StW1, StW2, StW3} state_e;

    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [LvlW-1:0]       level_q, level_d, need, pop_n;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic [DIV_W-1:0]      eff_div, cnt_q, cnt_d, cnt_cur;
    logic                  loaded_q, loaded_d, tick;
    state_e                state_q, state_d;
    logic [7:0]            l_q, l_d, r_q, r_d, l_byte, r_byte;
    logic [7:0]            sd_data_q, sd_data_d;
    logic [1:0]            sd_sel_q, sd_sel_d;
    logic                  sd_wr_q, sd_wr_d;
    logic                  ready, start, push;

    // While disabled (or straight out of reset) the count tracks rate_div live.
    always_comb begin
        eff_div  = (rate_div < DIV_W'(3)) ? DIV_W'(3) : rate_div;
        cnt_cur  = loaded_q ? cnt_q : eff_div;
        tick     = 1'b0;
        cnt_d    = eff_div;
        loaded_d = 1'b0;
        if (enable) begin
            loaded_d = 1'b1;
            if (cnt_cur == '0) begin
                tick  = 1'b1;
                cnt_d = eff_div;
            end else begin
                cnt_d = cnt_cur - DIV_W'(1);
            end
        end
    end

    // W3 is the last strobe cycle, so a tick there may start the next burst back-to-back.
    always_comb begin
        ready  = (state_q == StIdle) || (state_q == StW3);
        need   = stereo ? LvlW'(2) : LvlW'(1);
        start  = tick && ready && !fifo_clr && (level_q >= need);
        push   = fifo_wr && !fifo_clr && (level_q != LvlW'(Depth));
        pop_n  = start ? need : '0;
        l_byte = mem_q[head_q];
        r_byte = stereo ? mem_q[head_q + DEPTH_LOG2'(1)] : l_byte;

        head_d  = head_q + pop_n[DEPTH_LOG2-1:0];
        tail_d  = push ? tail_q + DEPTH_LOG2'(1) : tail_q;
        level_d = level_q + {{(LvlW-1){1'b0}}, push} - pop_n;
        ovf_d   = ovf_q | (fifo_wr && (level_q == LvlW'(Depth)));
        unf_d   = unf_q | (tick && ready && (level_q < need));
        if (fifo_clr) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        sd_wr_d   = 1'b0;
        sd_sel_d  = sd_sel_q;
        sd_data_d = sd_data_q;
        l_d       = l_q;
        r_d       = r_q;
        if (start) begin
            state_d   = StW0;
            sd_wr_d   = 1'b1;
            sd_sel_d  = 2'd0;
            sd_data_d = l_byte;
            l_d       = l_byte;
            r_d       = r_byte;
        end else begin
            unique case (state_q)
                StW0: begin
                    state_d   = StW1;
                    sd_wr_d   = 1'b1;
                    sd_sel_d  = 2'd1;
                    sd_data_d = l_q;
                end
                StW1: begin
                    state_d   = StW2;
                    sd_wr_d   = 1'b1;
                    sd_sel_d  = 2'd2;
                    sd_data_d = r_q;
                end
                StW2: begin
                    state_d   = StW3;
                    sd_wr_d   = 1'b1;
                    sd_sel_d  = 2'd3;
                    sd_data_d = r_q;
                end
                StW3:    state_d = StIdle;
                StIdle:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cnt_q     <= '0;
            loaded_q  <= 1'b0;
            state_q   <= StIdle;
            l_q       <= '0;
            r_q       <= '0;
            sd_data_q <= '0;
            sd_sel_q  <= '0;
            sd_wr_q   <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            cnt_q     <= cnt_d;
            loaded_q  <= loaded_d;
            state_q   <= state_d;
            l_q       <= l_d;
            r_q       <= r_d;
            sd_data_q <= sd_data_d;
            sd_sel_q  <= sd_sel_d;
            sd_wr_q   <= sd_wr_d;
        end
    end

    assign sd_data = sd_data_q;
    assign sd_sel  = sd_sel_q;
    assign sd_wr   = sd_wr_q;
    assign level   = level_q;
    assign empty   = (level_q == '0);
    assign full    = (level_q == LvlW'(Depth));
    assign ovf     = ovf_q;
    assign unf     = unf_q;

`ifdef SOUND_FIFO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= enable && (level_q <= LvlW'(Depth / 2));
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_sound_fifo.sv
// Self-checking bench for sound_fifo: randomized playback against a queue-based model.
module tb_sound_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = '0;
    logic        fifo_wr = 1'b0, fifo_clr = 1'b0, enable = 1'b0, stereo = 1'b0;
    logic [11:0] rate_div = 12'd9;
    logic [7:0]  sd_data;
    logic [1:0]  sd_sel;
    logic        sd_wr;
    logic [5:0]  level;
    logic        empty, full, ovf, unf;
`ifdef SOUND_FIFO_IRQ_EN
    logic        irq;
`endif

    sound_fifo #(.DEPTH_LOG2(5), .DIV_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .fifo_wr(fifo_wr), .fifo_clr(fifo_clr),
        .enable(enable), .stereo(stereo), .rate_div(rate_div), .sd_data(sd_data),
        .sd_sel(sd_sel), .sd_wr(sd_wr), .level(level), .empty(empty), .full(full),
        .ovf(ovf), .unf(unf)
`ifdef SOUND_FIFO_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log: cycle of each sd_wr plus {sel, data}.
    int         log_cyc[$];
    logic [9:0] log_sd[$];
    always @(negedge clk) begin
        if (rst_n && sd_wr) begin
            log_cyc.push_back(cyc);
            log_sd.push_back({sd_sel, sd_data});
        end
    end

    logic [7:0] model[$];
    bit         model_ovf = 1'b0, model_unf = 1'b0;
    int         n_checks = 0, n_fail = 0;

    localparam logic [20:0] ResetVec = {8'h00, 2'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_wr = 1'b1;
        data_in = b;
        step();
        fifo_wr = 1'b0;
        if (model.size() < 32) model.push_back(b);
        else model_ovf = 1'b1;
    endtask

    task automatic do_clr();
        fifo_clr = 1'b1;
        step();
        fifo_clr = 1'b0;
        model.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endtask

    // Enable for nt ticks, then predict every strobe from the byte queue and the tick period.
    task automatic run_play(input string name, input int r, input bit st, input int nt);
        int         reff, need, base, c0, t;
        int         e_cyc[$];
        logic [9:0] e_sd[$];
        logic [7:0] lb, rb;
        reff = (r < 3) ? 3 : r;
        need = st ? 2 : 1;
        base = log_cyc.size();
        rate_div = 12'(r);
        stereo = st;
        enable = 1'b1;
        c0 = cyc;
        repeat (reff + (nt - 1) * (reff + 1) + 1) step();
        enable = 1'b0;
        repeat (6) step();
        for (int k = 0; k < nt; k++) begin
            t = c0 + reff + k * (reff + 1);
            if (model.size() >= need) begin
                lb = model.pop_front();
                rb = st ? model.pop_front() : lb;
                for (int s = 0; s < 4; s++) begin
                    e_cyc.push_back(t + 1 + s);
                    e_sd.push_back({2'(s), (s < 2) ? lb : rb});
                end
            end else begin
                model_unf = 1'b1;
            end
        end
        n_checks++;
        if (log_cyc.size() - base !== e_cyc.size()) begin
            n_fail++;
            $display("FAIL %s strobe count: got %0d want %0d", name, log_cyc.size() - base,
                     e_cyc.size());
        end
        for (int i = 0; i < e_cyc.size(); i++) begin
            if (base + i < log_cyc.size()) begin
                n_checks++;
                if (log_cyc[base+i] !== e_cyc[i] || log_sd[base+i] !== e_sd[i]) begin
                    n_fail++;
                    $display("FAIL %s strobe %0d: got cyc %0d sel/data %h, want cyc %0d %h",
                             name, i, log_cyc[base+i] - c0, log_sd[base+i], e_cyc[i] - c0,
                             e_sd[i]);
                end
            end
        end
        n_checks++;
        if ({level, empty, ovf, unf} !== {6'(model.size()), model.size() == 0, model_ovf,
                                          model_unf}) begin
            n_fail++;
            $display("FAIL %s status: got level %0d empty %b ovf %b unf %b, want %0d %b %b %b",
                     name, level, empty, ovf, unf, model.size(), model.size() == 0, model_ovf,
                     model_unf);
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({sd_data, sd_sel, sd_wr, level, empty, full, ovf, unf} !== ResetVec) begin
            n_fail++;
            $display("FAIL reset_assert: got %h want %h",
                     {sd_data, sd_sel, sd_wr, level, empty, full, ovf, unf}, ResetVec);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({sd_data, sd_sel, sd_wr, level, empty, full, ovf, unf} !== ResetVec) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h",
                     {sd_data, sd_sel, sd_wr, level, empty, full, ovf, unf}, ResetVec);
        end
    endtask

    task automatic test_mono();
        do_clr();
        push_byte(8'h11);
        push_byte(8'h22);
        run_play("mono", 9, 1'b0, 3);
        n_checks++;
        if (unf !== 1'b1) begin
            n_fail++;
            $display("FAIL mono_unf: got %b want 1", unf);
        end
    endtask

    task automatic test_stereo();
        do_clr();
        push_byte(8'hA0);
        push_byte(8'h5F);
        run_play("stereo", 5, 1'b1, 1);
    endtask

    // Pointers start mid-buffer here (left at 2 by the stereo run), so the fill wraps.
    task automatic test_fill_wrap();
        for (int i = 1; i <= 33; i++) push_byte(8'(i));
        n_checks++;
        if ({full, level, ovf} !== {1'b1, 6'd32, 1'b1}) begin
            n_fail++;
            $display("FAIL fill: got full %b level %0d ovf %b want 1 32 1", full, level, ovf);
        end
        run_play("drain", 3, 1'b1, 16);
    endtask

    task automatic test_push_pop();
        int c0;
        do_clr();
        for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
        rate_div = 12'd5;
        stereo = 1'b0;
        enable = 1'b1;
        c0 = cyc;
        repeat (5) step();
        fifo_wr = 1'b1;
        data_in = 8'h77;
        n_checks++;
        if (level !== 6'd5) begin
            n_fail++;
            $display("FAIL push_pop_before: got level %0d want 5", level);
        end
        step();
        fifo_wr = 1'b0;
        enable = 1'b0;
        void'(model.pop_front());
        model.push_back(8'h77);
        n_checks++;
        if (level !== 6'd5) begin
            n_fail++;
            $display("FAIL push_pop_same_cycle: got level %0d want 5 (cyc %0d)", level,
                     cyc - c0);
        end
        repeat (6) step();
        fifo_clr = 1'b1;
        fifo_wr = 1'b1;
        step();
        fifo_clr = 1'b0;
        fifo_wr = 1'b0;
        model.delete();
        n_checks++;
        if ({level, empty} !== {6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_with_push: got level %0d empty %b want 0 1", level, empty);
        end
    endtask

    task automatic test_fast_rate();
        do_clr();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
        run_play("fast_rate", 1, 1'b0, 4);
    endtask

    task automatic test_reset_mid();
        int base;
        do_clr();
        push_byte(8'h3C);
        push_byte(8'hC3);
        rate_div = 12'd3;
        stereo = 1'b0;
        enable = 1'b1;
        repeat (5) step();
        n_checks++;
        if ({sd_wr, sd_sel, sd_data} !== {1'b1, 2'd1, 8'h3C}) begin
            n_fail++;
            $display("FAIL mid_w1: got wr %b sel %0d data %h want 1 1 3c", sd_wr, sd_sel,
                     sd_data);
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({sd_data, sd_sel, sd_wr, level, empty, full, ovf, unf} !== ResetVec) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want %h",
                     {sd_data, sd_sel, sd_wr, level, empty, full, ovf, unf}, ResetVec);
        end
        base = log_cyc.size();
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        model.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        n_checks++;
        if (log_cyc.size() - base !== 0 || sd_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_residual: got %0d strobes wr %b want 0 0", log_cyc.size() - base,
                     sd_wr);
        end
    endtask

    task automatic test_random();
        int n, r, nt;
        bit st;
        for (int it = 0; it < 8; it++) begin
            do_clr();
            n  = $urandom_range(0, 10);
            st = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 7);
            nt = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
            run_play("random", r, st, nt);
        end
    endtask

`ifdef SOUND_FIFO_IRQ_EN
    task automatic test_irq();
        do_clr();
        rate_div = 12'd4095;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        step();
        n_checks++;
        if ({level, irq} !== {6'd16, 1'b1}) begin
            n_fail++;
            $display("FAIL irq_half: got level %0d irq %b want 16 1", level, irq);
        end
        push_byte(8'h10);
        n_checks++;
        if ({level, irq} !== {6'd17, 1'b1}) begin
            n_fail++;
            $display("FAIL irq_lag: got level %0d irq %b want 17 1", level, irq);
        end
        step();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_drop: got %b want 0", irq);
        end
        enable = 1'b0;
        do_clr();
    endtask
`endif

    initial begin
        test_reset();
        test_mono();
        test_stereo();
        test_fill_wrap();
        test_push_pop();
        test_fast_rate();
        test_reset_mid();
        test_random();
`ifdef SOUND_FIFO_IRQ_EN
        test_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_fifo.md
# sound_fifo

Sample FIFO and rate-timer sequencer feeding the Soundrive/Covox DAC register stage. CPU writes sample bytes into a small FIFO. A programmable sample-rate timer pops one sample (mono) or one left/right pair (stereo) per tick. It replays the samples as `sd_wr` strobes on the four DAC channel registers, channels 0/1 for left and 2/3 for right, so playback needs no per-sample CPU port writes.

## Interface
- `DEPTH_LOG2`, 5: FIFO depth is 2^DEPTH_LOG2 bytes (32).
- `DIV_W`, 12: width of the sample-rate divider.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  sample byte from the CPU data bus.
- `fifo_wr`  in  1  one-cycle strobe; pushes `data_in`.
- `fifo_clr`  in  1  one-cycle strobe; empties the FIFO and clears the `ovf`/`unf` flags.
- `enable`  in  1  playback enable.
- `stereo`  in  1  0 = mono (1 byte/tick), 1 = stereo (L then R byte/tick).
- `rate_div`  in  DIV_W  tick period minus one, in `clk` cycles.
- `sd_data`  out  8  byte to the DAC channel register.
- `sd_sel`  out  2  DAC channel index 0..3.
- `sd_wr`  out  1  one-cycle channel write strobe.
- `level`  out  DEPTH_LOG2+1  bytes currently stored.
- `empty`, `full`  out  1  FIFO status.
- `ovf`, `unf`  out  1  sticky overflow and underrun flags.
- `irq`  out  1  half-empty request; present only with `SOUND_FIFO_IRQ_EN`.

## Operation
- Reset values: `sd_data`=0, `sd_sel`=0, `sd_wr`=0, `level`=0, `empty`=1, `full`=0, `ovf`=0, `unf`=0, `irq`=0. Timer is loaded with `rate_div` and the FSM is in IDLE.
- FIFO is circular, with DEPTH_LOG2-bit head and tail pointers that wrap modulo depth. `level` is the exact count, 0..2^DEPTH_LOG2.
- Push when full: the byte is dropped and `ovf` is set. A push and a pop in the same cycle both take effect, and `level` is unchanged.
- `fifo_clr` has priority over push and pop in the same cycle. It resets the pointers and `level` and clears `ovf`/`unf`. It does not abort a write sequence in progress; the remaining strobes of that sequence carry their already-latched bytes.
- Timer:
  - While `enable`=1 the timer counts down. At 0 it generates `tick` and reloads `rate_div`, so the period is `rate_div`+1 cycles.
  - Effective `rate_div` values below 3 are clamped to 3, so a sequence (4 cycles) always completes before the next tick.
  - While `enable`=0 the timer holds at `rate_div`.
  - A change to `rate_div` takes effect at the next reload.
- FSM states are IDLE, W0, W1, W2, W3. At `tick` in IDLE:
  - Mono, `level`>=1: latch the head byte into L and R, pop 1, go to W0.
  - Stereo, `level`>=2: latch head into L and head+1 into R, pop 2, go to W0.
  - Insufficient data: no pop, set `unf`, stay in IDLE, and issue no writes. The DAC holds its previous value.
- W0..W3 each issue one `sd_wr` with `sd_sel` = 0, 1, 2, 3 in turn. `sd_data` is L in W0/W1 and R in W2/W3. After W3 the FSM returns to IDLE.
- Deasserting `enable` mid-sequence lets the sequence finish; no new tick occurs.
- Pops occur only in the tick cycle; pushes may land in any cycle.

## Timing
- Tick at cycle T causes the pop at T and `sd_wr` strobes at T+1, T+2, T+3, T+4.
- `sd_data` and `sd_sel` are registered and valid in the same cycle as `sd_wr`. Outside a strobe they hold their last values.
- `level`, `empty` and `full` update the cycle after the push or pop edge.
- `ovf` and `unf` set the cycle after the event and stay set until `fifo_clr` or reset.
- Reset asserted mid-sequence: all outputs go to their reset values immediately, with no residual strobes.

## Configuration
- `SOUND_FIFO_IRQ_EN` defined: `irq` is a registered level, high while `enable`=1 and `level` <= 2^(DEPTH_LOG2-1). It drops the cycle after `level` exceeds half.
- `SOUND_FIFO_IRQ_EN` not defined: the `irq` port and its logic are absent, and everything else is unchanged.

## Test plan
- Mono, `rate_div`=9: push 0x11, 0x22. Required: `sd_wr` bursts 10 cycles apart; the first burst carries 0x11 on sel 0..3, the second 0x22. The third tick leaves `unf`=1 with no strobes.
- Stereo: push 0xA0, 0x5F. Required: one burst sel0=0xA0, sel1=0xA0, sel2=0x5F, sel3=0x5F, then `level`=0, `empty`=1.
- Push 33 bytes with `enable`=0. Required: `full`=1, `level`=32, `ovf`=1. Popping 32 bytes returns bytes 1..32 in order, with the pointer wrap exercised.
- Push in the same cycle as a tick pop at `level`=5. Required: `level` stays 5. `fifo_clr` together with a push yields `level`=0.
- `rate_div`=1. Required: tick period is 4 cycles and bursts are back-to-back with no overlap. Assert `rst_n` low during W1: `sd_wr`=0 immediately and all outputs at reset values.
- With `SOUND_FIFO_IRQ_EN`, depth 32: `irq`=1 at `level`=16, `irq`=0 one cycle after the 17th byte lands.
